mac_result_drain: RTL and testbench
===================================

MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

Interface
REQ-001 SHALL have parameter RESULT_WIDTH, default 40, meaning the width of the MAC result word accepted.
REQ-002 SHALL have parameter BEAT_WIDTH, default 8, meaning the output beat width; RESULT_WIDTH SHALL be an integer multiple of BEAT_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered results; it SHALL be a power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port in_val, input, RESULT_WIDTH bits, the result word from the MAC.
REQ-007 SHALL have port in_valid, input, 1 bit, result-valid strobe; there is no backpressure toward the MAC.
REQ-008 SHALL have port out_data, output, BEAT_WIDTH bits, the current beat.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream accept.
REQ-011 SHALL have port out_last, output, 1 bit, high on the final beat of a result.
REQ-012 SHALL have port overflow, output, 1 bit, sticky flag for a dropped result.
REQ-013 SHALL have port ovf_clr, input, 1 bit, synchronous clear of overflow.
REQ-014 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits, the FIFO occupancy.
REQ-015 SHALL have port result_count, output, 16 bits, the number of results fully transmitted.

Function
REQ-016 SHALL sample in_val into the FIFO at each rising edge where in_valid=1 and the FIFO is not full.
REQ-017 SHALL drop the word and set overflow when in_valid=1 and the FIFO is full, unless the FIFO pops at the same edge; in that case the word SHALL be accepted.
REQ-018 SHALL define BEATS = RESULT_WIDTH/BEAT_WIDTH (5 at defaults) and transmit each result as BEATS beats, most-significant beat first.
REQ-019 SHALL implement FSM states IDLE (out_valid=0) and SEND (out_valid=1), with a beat index from 0 to BEATS-1.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop the head into the shift register at the next edge, clear the beat index, and enter SEND.
REQ-021 SHALL produce out_valid=1 at the first edge after the push edge, for a word pushed into an empty FIFO while in IDLE.
REQ-022 SHALL hold out_data, out_valid and out_last stable in SEND while out_ready=0.
REQ-023 SHALL, on a handshake (out_valid and out_ready) with a non-final beat, advance the index by 1 and shift by BEAT_WIDTH.
REQ-024 SHALL, on a final-beat handshake, pop and load the next result with no idle cycle if the FIFO is non-empty; otherwise it SHALL return to IDLE.
REQ-025 SHALL drive out_last = 1 exactly when in SEND and the index equals BEATS-1.
REQ-026 SHALL let ovf_clr win over a simultaneous overflow event: the flag clears that cycle, and a later drop sets it again.
REQ-027 SHALL make fifo_count reflect simultaneous push and pop (net unchanged) and exclude the word in the shift register.

Reset
REQ-028 SHALL, while rst=1, immediately force the FSM to IDLE, empty the FIFO, and set out_valid=0, out_last=0, out_data=0, overflow=0, fifo_count=0 and result_count=0.
REQ-029 SHALL discard without output any result that is partly transmitted when reset asserts; after reset releases, the first in_valid is handled per REQ-016.

Configuration
REQ-030 SHALL, with macro MAC_DRAIN_STATS_EN defined, increment result_count at each final-beat handshake and wrap 0xFFFF to 0x0000.
REQ-031 SHALL, with MAC_DRAIN_STATS_EN undefined, tie result_count to 0 and include no counter logic.

Structure
REQ-032 SHALL place the FSM state enum typedef and the default RESULT_WIDTH/BEAT_WIDTH constants in the shared package mac_pkg.
REQ-033 SHALL implement the buffer as one sub-module, mac_drain_fifo: a synchronous FIFO with push, pop, full, empty and count.

Verification
REQ-034 SHALL cover: single push in_val=40'h01_2345_6789 with out_ready=1 -> beats 01,23,45,67,89 on consecutive cycles, out_last on 89, then IDLE.
REQ-035 SHALL cover: 3 back-to-back pushes with out_ready=1 -> 15 beats and no out_valid gap between results.
REQ-036 SHALL cover: 6 consecutive pushes with out_ready=0 -> fifo_count=4 plus 1 in the shift register, 1 drop, overflow=1; pulsing ovf_clr -> overflow=0.
REQ-037 SHALL cover: out_ready toggling every cycle on 40'hAA_BB_CC_DD_EE -> out_data held while stalled and the beat order unchanged.
REQ-038 SHALL cover: rst asserted during beat 2 -> out_valid=0 immediately, fifo_count=0, and after release a new push is sent from its first beat.
REQ-039 SHALL cover: with MAC_DRAIN_STATS_EN, 65537 results sent -> result_count=1; without the macro, result_count stays 0.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and default widths for the MAC result drain
package mac_pkg;

  localparam int MAC_RESULT_WIDTH = 40;
  localparam int MAC_BEAT_WIDTH   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/mac_drain_fifo.sv
// rtl/mac_drain_fifo.sv - synchronous FIFO buffering MAC results ahead of the serializer
module mac_drain_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Storage array is write-only on push; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mac_result_drain.sv
// rtl/mac_result_drain.sv - buffers MAC results and drains them as MSB-first beats; optional MAC_DRAIN_STATS_EN adds a result counter
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int RESULT_WIDTH = MAC_RESULT_WIDTH,
  parameter int BEAT_WIDTH   = MAC_BEAT_WIDTH,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RESULT_WIDTH-1:0]       in_val,
  input  logic                          in_valid,
  output logic [BEAT_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   result_count
);

  localparam int BEATS = RESULT_WIDTH / BEAT_WIDTH;
  localparam int IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BEATS - 1);

  drain_state_t            r_state;
  drain_state_t            w_state_nxt;
  logic [RESULT_WIDTH-1:0] r_shift;
  logic [IDXW-1:0]         r_idx;
  logic                    r_overflow;

  logic [RESULT_WIDTH-1:0] w_fifo_data;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_hs;
  logic                    w_final;
  logic                    w_drop;

  assign w_hs    = (r_state == ST_SEND) && out_ready;
  assign w_final = w_hs && (r_idx == LAST_IDX);
  // A pop in the same edge frees a slot, so a full FIFO still accepts the word.
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  mac_drain_fifo #(
    .WIDTH (RESULT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_val),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and pop decision: load from IDLE, or chain straight into the next result after the last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_final) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift register and beat index; the top beat of r_shift is always the one on out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_shift <= w_fifo_data;
      r_idx   <= '0;
    end else if (w_hs && !w_final) begin
      r_shift <= r_shift << BEAT_WIDTH;
      r_idx   <= r_idx + 1'b1;
    end
  end

  // Sticky drop flag; a clear in the same cycle as a drop wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_overflow <= 1'b0;
    else if (ovf_clr) r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
  end

  assign out_data  = r_shift[RESULT_WIDTH-1 -: BEAT_WIDTH];
  assign out_valid = (r_state == ST_SEND);
  assign out_last  = (r_state == ST_SEND) && (r_idx == LAST_IDX);
  assign overflow  = r_overflow;

`ifdef MAC_DRAIN_STATS_EN
  logic [15:0] r_result_count;

  // Count fully transmitted results, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_result_count <= '0;
    else if (w_final) r_result_count <= r_result_count + 16'd1;
  end

  assign result_count = r_result_count;
`else
  assign result_count = '0;
`endif

endmodule

// File: tb/tb_mac_result_drain.sv
// tb/tb_mac_result_drain.sv - randomized and directed bench for mac_result_drain against a queue-based model
module tb_mac_result_drain;

  localparam int RW    = 40;
  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int BEATS = RW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] in_val;
  logic          in_valid;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          overflow;
  logic          ovf_clr;
  logic [2:0]    fifo_count;
  logic [15:0]   result_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] m_fifo  [$];
  logic [BW-1:0] m_beats [$];
  logic          m_ovf;
  int unsigned   m_rcount;

  mac_result_drain #(
    .RESULT_WIDTH (RW),
    .BEAT_WIDTH   (BW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_val       (in_val),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .fifo_count   (fifo_count),
    .result_count (result_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_rcount();
`ifdef MAC_DRAIN_STATS_EN
    return 16'(m_rcount);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_beats.size() > 0));
    check("out_last", 64'(out_last), 64'(m_beats.size() == 1));
    if (m_beats.size() > 0) check("out_data", 64'(out_data), 64'(m_beats[0]));
    check("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("result_count", 64'(result_count), 64'(exp_rcount()));
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_beats.delete();
    m_ovf    = 1'b0;
    m_rcount = 0;
  endtask

  // One clock: drive inputs, predict the edge from the transaction rules, then compare.
  task automatic step(input logic iv, input logic [RW-1:0] v, input logic rdy, input logic clr);
    bit hs, fin, pop, acc;
    logic [RW-1:0] w;
    in_valid  = iv;
    in_val    = v;
    out_ready = rdy;
    ovf_clr   = clr;
    hs  = (m_beats.size() > 0) && rdy;
    fin = hs && (m_beats.size() == 1);
    pop = (m_fifo.size() > 0) && ((m_beats.size() == 0) || fin);
    acc = iv && ((m_fifo.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (hs) void'(m_beats.pop_front());
    if (fin) m_rcount++;
    if (pop) begin
      w = m_fifo.pop_front();
      for (int b = BEATS - 1; b >= 0; b--) m_beats.push_back(w[b*BW +: BW]);
    end
    if (acc) m_fifo.push_back(v);
    if (clr) m_ovf = 1'b0;
    else if (iv && !acc) m_ovf = 1'b1;
    check_outputs();
  endtask

  task automatic reset_now();
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    rst      = 1'b1;
    #1;
    model_clear();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_result_count", 64'(result_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [RW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[RW-1:0];
  endfunction

  initial begin
    logic [BW-1:0] exp_single [BEATS];
    logic [BW-1:0] exp_toggle [BEATS];
    logic [BW-1:0] seen [$];
    int vcount, rises;
    logic prev_v;

    exp_single = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
    exp_toggle = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    in_val    = '0;
    out_ready = 1'b0;
    reset_now();

    // Single result drained at full rate.
    step(1'b1, 40'h01_2345_6789, 1'b1, 1'b0);
    for (int i = 0; i < BEATS; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("single_beat", 64'(out_data), 64'(exp_single[i]));
      check("single_last", 64'(out_last), 64'(i == BEATS - 1));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check("single_idle", 64'(out_valid), 64'd0);

    // Three back-to-back results with no gap.
    vcount = 0;
    rises  = 0;
    prev_v = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step(i < 3, rand_word(), 1'b1, 1'b0);
      if (out_valid) vcount++;
      if (out_valid && !prev_v) rises++;
      prev_v = out_valid;
    end
    check("b2b_beats", 64'(vcount), 64'd15);
    check("b2b_no_gap", 64'(rises), 64'd1);

    // Six pushes against a stalled sink: one drop, then clear.
    for (int i = 0; i < 6; i++) step(1'b1, rand_word(), 1'b0, 1'b0);
    check("ovf_fifo_full", 64'(fifo_count), 64'd4);
    check("ovf_set", 64'(overflow), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovf_cleared", 64'(overflow), 64'd0);
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Ready toggling every cycle keeps beat order.
    step(1'b1, 40'hAA_BB_CC_DD_EE, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      if (out_valid && i[0]) seen.push_back(out_data);
      step(1'b0, '0, i[0], 1'b0);
    end
    check("toggle_count", 64'(seen.size()), 64'(BEATS));
    for (int i = 0; i < BEATS; i++) begin
      if (i < seen.size()) check("toggle_beat", 64'(seen[i]), 64'(exp_toggle[i]));
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Reset during beat 2, then a fresh result starts from its first beat.
    step(1'b1, 40'h11_2233_4455, 1'b1, 1'b0);
    step(1'b1, 40'h99_8877_6655, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("pre_rst_beat2", 64'(out_data), 64'h33);
    reset_now();
    step(1'b1, 40'h66_7788_9900, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_first", 64'(out_data), 64'h66);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic with occasional bursts, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      int pin;
      pin = ((i / 200) % 2 == 1) ? 85 : 35;
      if ($urandom_range(0, 599) == 0) reset_now();
      step($urandom_range(0, 99) < pin, rand_word(),
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
